// File: rtl/wb_trace_pkg.sv
// Shared types for the commit-trace checker: trace entry layout, error causes
// and checker state encoding.
package wb_trace_pkg;

   localparam int TRACE_W = 70;

   // One retired instruction as seen at write-back; ena is stored normalised (rd=0 -> ena=0).
   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] value;
   } trace_t;

   localparam logic [2:0] CAUSE_NONE  = 3'd0;
   localparam logic [2:0] CAUSE_PC    = 3'd1;
   localparam logic [2:0] CAUSE_DEST  = 3'd2;
   localparam logic [2:0] CAUSE_VALUE = 3'd3;
   localparam logic [2:0] CAUSE_OVF   = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   // Writes to x0 never update architectural state, so they compare as no-write.
   function automatic logic norm_ena(input logic ena, input logic [4:0] rd);
      return ena && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH-entry FIFO of trace entries with wrap-bit pointers.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module trace_fifo
   import wb_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  trace_t wdata,
   output trace_t rdata,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [TRACE_W-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               pop_ok;
   logic               push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = trace_t'(mem[rd_ptr[AW-1:0]]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares the CPU's write-back commit trace, in order, against a golden
// stream and latches a pass/fail verdict plus the first error record.
module wb_trace_checker
   import wb_trace_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter int unsigned HALT_REPEAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        debug_wb_have_inst,
   input  logic [31:0] debug_wb_pc,
   input  logic        debug_wb_ena,
   input  logic [4:0]  debug_wb_reg,
   input  logic [31:0] debug_wb_value,
   input  logic        ref_valid,
   output logic        ref_ready,
   input  logic [31:0] ref_pc,
   input  logic        ref_ena,
   input  logic [4:0]  ref_reg,
   input  logic [31:0] ref_value,
   output logic        pass,
   output logic        fail,
   output logic [2:0]  err_cause,
   output logic [31:0] err_pc,
   output logic [31:0] err_exp,
   output logic [31:0] err_got,
   output logic [31:0] inst_cnt
);

   state_t      state;
   trace_t      push_entry;
   trace_t      head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        overflow;
   logic        gold_ena;
   logic [2:0]  cmp_cause;
   logic [31:0] cmp_exp;
   logic [31:0] cmp_got;
   logic [31:0] last_pc;
   logic        last_vld;
   logic [31:0] rep_cnt;
   logic [31:0] rep_next;

   assign push_entry = '{pc:    debug_wb_pc,
                         ena:   norm_ena(debug_wb_ena, debug_wb_reg),
                         rd:    debug_wb_reg,
                         value: debug_wb_value};

   assign push      = (state == ST_RUN) && debug_wb_have_inst;
   assign ref_ready = !rst && (state == ST_RUN) && !fifo_empty;
   assign pop       = ref_valid && ref_ready;
   assign overflow  = push && fifo_full && !pop;
   assign gold_ena  = norm_ena(ref_ena, ref_reg);

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      cmp_cause = CAUSE_NONE;
      cmp_exp   = '0;
      cmp_got   = '0;
      if (head.pc != ref_pc) begin
         cmp_cause = CAUSE_PC;
         cmp_exp   = ref_pc;
         cmp_got   = head.pc;
      end else if ((head.ena != gold_ena) || (gold_ena && (head.rd != ref_reg))) begin
         cmp_cause = CAUSE_DEST;
         cmp_exp   = {26'b0, gold_ena, ref_reg};
         cmp_got   = {26'b0, head.ena, head.rd};
      end else if (gold_ena && (head.value != ref_value)) begin
         cmp_cause = CAUSE_VALUE;
         cmp_exp   = ref_value;
         cmp_got   = head.value;
      end
   end

   // The self-loop halt shows up as the same PC committing back-to-back.
   assign rep_next = (last_vld && (head.pc == last_pc)) ? rep_cnt + 32'd1 : 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         pass      <= 1'b0;
         fail      <= 1'b0;
         err_cause <= CAUSE_NONE;
         err_pc    <= '0;
         err_exp   <= '0;
         err_got   <= '0;
         inst_cnt  <= '0;
         last_pc   <= '0;
         last_vld  <= 1'b0;
         rep_cnt   <= '0;
      end else if (state == ST_RUN) begin
         if (overflow) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            err_cause <= CAUSE_OVF;
            err_pc    <= debug_wb_pc;
            err_exp   <= '0;
            err_got   <= '0;
         end else if (pop) begin
            if (cmp_cause != CAUSE_NONE) begin
               state     <= ST_FAIL;
               fail      <= 1'b1;
               err_cause <= cmp_cause;
               err_pc    <= head.pc;
               err_exp   <= cmp_exp;
               err_got   <= cmp_got;
            end else begin
               if (inst_cnt != '1) inst_cnt <= inst_cnt + 32'd1;
               last_pc  <= head.pc;
               last_vld <= 1'b1;
               rep_cnt  <= rep_next;
               if (rep_next >= HALT_REPEAT) begin
                  state <= ST_PASS;
                  pass  <= 1'b1;
               end
            end
         end
      end
   end

endmodule
